// File: rtl/corr_filter_buf.sv
// Bounds filter for the correspondence stream, followed by a show-ahead FIFO.
// Tracks the frame lifecycle and reports the accepted count, overflow and restart errors.
module corr_filter_buf #(
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_BW        = 20,
  parameter int BORDER_BW     = 4,
  parameter int DATA_DEPTH_BW = 16,
  parameter int H_SIZE_BW     = 11,
  parameter int V_SIZE_BW     = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_frame_start,
  input  logic                     i_frame_end,
  input  logic                     i_valid,
  input  logic [DATA_DEPTH_BW-1:0] i_depth0,
  input  logic [H_SIZE_BW-1:0]     i_idx0_x,
  input  logic [V_SIZE_BW-1:0]     i_idx0_y,
  input  logic [H_SIZE_BW-1:0]     i_idx1_x,
  input  logic [V_SIZE_BW-1:0]     i_idx1_y,
  input  logic [H_SIZE_BW-1:0]     r_hsize,
  input  logic [V_SIZE_BW-1:0]     r_vsize,
  input  logic [BORDER_BW-1:0]     r_border,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_DEPTH_BW-1:0] o_depth0,
  output logic [H_SIZE_BW-1:0]     o_idx0_x,
  output logic [V_SIZE_BW-1:0]     o_idx0_y,
  output logic [H_SIZE_BW-1:0]     o_idx1_x,
  output logic [V_SIZE_BW-1:0]     o_idx1_y,
  output logic                     o_frame_done,
  output logic [CNT_BW-1:0]        o_corr_cnt,
  output logic                     o_overflow,
  output logic                     o_restart_err,
  output logic [1:0]               o_state
);
  // Output handshake: an entry moves when o_valid && i_ready at the rising edge;
  // while i_ready is low the head entry and o_valid stay stable.

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_DEPTH_BW + 2*H_SIZE_BW + 2*V_SIZE_BW;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic             eff_run, restart, pass_x, pass_y;
  logic [H_SIZE_BW:0] bx;
  logic [V_SIZE_BW:0] by;
  logic             pipe_vld;
  logic [ENT_W-1:0] pipe_ent, head;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             empty, full, pop, wr_en, drain_done;
  logic [CNT_BW-1:0] run_cnt;

  assign eff_run = (state == RUN) || i_frame_start;
  assign restart = i_frame_start && (state != IDLE);

  // Extra bit on each side so x + border never wraps.
  assign bx     = (H_SIZE_BW+1)'(r_border);
  assign by     = (V_SIZE_BW+1)'(r_border);
  assign pass_x = ({1'b0, i_idx1_x} >= bx) && (({1'b0, i_idx1_x} + bx) < {1'b0, r_hsize});
  assign pass_y = ({1'b0, i_idx1_y} >= by) && (({1'b0, i_idx1_y} + by) < {1'b0, r_vsize});

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign o_valid = !empty;
  assign pop     = o_valid && i_ready;
  assign wr_en   = pipe_vld && (!full || pop);

  // True when neither the filter stage nor the FIFO will hold anything after this edge.
  assign drain_done = !pipe_vld && (empty || ((count == (AW+1)'(1)) && pop));

  assign head = mem[rd_ptr[AW-1:0]];
  assign {o_depth0, o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y} = o_valid ? head : '0;
  assign o_frame_done = (state == DONE);
  assign o_state      = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_frame_start) state_nx = RUN;
      RUN:     if (!i_frame_start && i_frame_end) state_nx = FLUSH;
      FLUSH:   if (i_frame_start) state_nx = RUN;
               else if (drain_done) state_nx = DONE;
      DONE:    state_nx = i_frame_start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pipe_vld      <= 1'b0;
      run_cnt       <= '0;
      o_corr_cnt    <= '0;
      o_overflow    <= 1'b0;
      o_restart_err <= 1'b0;
    end else begin
      state         <= state_nx;
      pipe_vld      <= eff_run && i_valid && pass_x && pass_y;
      o_restart_err <= restart;
      if (restart) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
      if (i_frame_start) run_cnt <= '0;
      else if (wr_en && (run_cnt != '1)) run_cnt <= run_cnt + 1'b1;
      if (i_frame_start) o_overflow <= 1'b0;
      else if (pipe_vld && !wr_en) o_overflow <= 1'b1;
      if (state == FLUSH && !i_frame_start && drain_done) o_corr_cnt <= run_cnt;
    end
  end

  // Payload storage carries no reset; it is only observed while o_valid is high.
  always_ff @(posedge i_clk) begin
    pipe_ent <= {i_depth0, i_idx0_x, i_idx0_y, i_idx1_x, i_idx1_y};
    if (wr_en) mem[wr_ptr[AW-1:0]] <= pipe_ent;
  end

endmodule
